// File: rtl/trivium_decrypt_if.sv
// Handshake bundle for trivium_decrypt: control, ciphertext in, plaintext out.
// Optional keystream monitor port appears when TRIVIUM_KS_MON_EN is defined.
interface trivium_decrypt_if #(
  parameter int unsigned W = 8
) ();
  logic          start;
  logic [79:0]   key;
  logic [79:0]   iv;
  logic          ready;
  logic          busy;
  logic          ct_valid;
  logic          ct_ready;
  logic [W-1:0]  ct_data;
  logic          ct_last;
  logic          pt_valid;
  logic          pt_ready;
  logic [W-1:0]  pt_data;
  logic          pt_last;
  logic [15:0]   beat_cnt;
`ifdef TRIVIUM_KS_MON_EN
  logic [W-1:0]  ks_mon;

  modport master (
    output start, key, iv, ct_valid, ct_data, ct_last, pt_ready,
    input  ready, busy, ct_ready, pt_valid, pt_data, pt_last, beat_cnt, ks_mon
  );

  modport slave (
    input  start, key, iv, ct_valid, ct_data, ct_last, pt_ready,
    output ready, busy, ct_ready, pt_valid, pt_data, pt_last, beat_cnt, ks_mon
  );
`else
  modport master (
    output start, key, iv, ct_valid, ct_data, ct_last, pt_ready,
    input  ready, busy, ct_ready, pt_valid, pt_data, pt_last, beat_cnt
  );

  modport slave (
    input  start, key, iv, ct_valid, ct_data, ct_last, pt_ready,
    output ready, busy, ct_ready, pt_valid, pt_data, pt_last, beat_cnt
  );
`endif
endinterface

// File: rtl/trivium_decrypt.sv
// Streaming Trivium decryptor: key/IV load, warm-up, then W keystream bits per
// accepted ciphertext beat XORed into a single registered plaintext stage.
// Optional feature macro: TRIVIUM_KS_MON_EN adds ks_mon (keystream of pt_data).
module trivium_decrypt #(
  parameter int unsigned W      = 8,
  parameter int unsigned WARMUP = 1152
) (
  input  logic             clk,
  input  logic             reset,
  trivium_decrypt_if.slave bus
);

  localparam int unsigned WarmCycles = WARMUP / W;
  localparam int unsigned CntW       = (WarmCycles > 1) ? $clog2(WarmCycles) : 1;
  localparam logic [CntW-1:0] WarmLast = CntW'(WarmCycles - 1);

  typedef enum logic [1:0] {StIdle, StWarm, StRun} state_e;

  state_e          state_q, state_d;
  logic [287:0]    s_q, s_next;
  logic [CntW-1:0] warm_cnt_q;
  logic [W-1:0]    ks_word;
  logic            pt_valid_q, pt_last_q;
  logic [W-1:0]    pt_data_q;
  logic [15:0]     beat_cnt_q;
  logic            load, warm_adv, ct_hs;
  logic            ready, busy, ct_ready;
`ifdef TRIVIUM_KS_MON_EN
  logic [W-1:0]    ks_mon_q;
`endif

  // W Trivium rounds unrolled; round 0's keystream bit lands in the MSB.
  always_comb begin
    logic [287:0] s;
    logic t1, t2, t3;
    s       = s_q;
    t1      = 1'b0;
    t2      = 1'b0;
    t3      = 1'b0;
    ks_word = '0;
    for (int r = 0; r < W; r++) begin
      t1 = s[65] ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      ks_word[W-1-r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[90] & s[91]) ^ s[170];
      t2 = t2 ^ (s[174] & s[175]) ^ s[263];
      t3 = t3 ^ (s[285] & s[286]) ^ s[68];
      s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    s_next = s;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    warm_adv = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    ct_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A pending plaintext beat blocks a new message until it drains.
        ready = ~pt_valid_q;
        if (bus.start && ready) begin
          load    = 1'b1;
          state_d = StWarm;
        end
      end
      StWarm: begin
        busy     = 1'b1;
        warm_adv = 1'b1;
        if (warm_cnt_q == WarmLast) state_d = StRun;
      end
      StRun: begin
        busy     = 1'b1;
        ct_ready = ~pt_valid_q | bus.pt_ready;
        if (bus.ct_valid && ct_ready && bus.ct_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ct_hs = bus.ct_valid & ct_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Cipher state, warm-up counter and plaintext output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q        <= '0;
      warm_cnt_q <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
      pt_last_q  <= 1'b0;
      beat_cnt_q <= '0;
`ifdef TRIVIUM_KS_MON_EN
      ks_mon_q   <= '0;
`endif
    end else begin
      if (load) begin
        s_q        <= {3'b111, 112'b0, bus.iv, 13'b0, bus.key};
        warm_cnt_q <= '0;
        beat_cnt_q <= '0;
      end else if (warm_adv) begin
        s_q        <= s_next;
        warm_cnt_q <= warm_cnt_q + 1'b1;
      end else if (ct_hs) begin
        s_q <= s_next;
      end

      if (ct_hs) begin
        pt_valid_q <= 1'b1;
        pt_data_q  <= bus.ct_data ^ ks_word;
        pt_last_q  <= bus.ct_last;
`ifdef TRIVIUM_KS_MON_EN
        ks_mon_q   <= ks_word;
`endif
        if (beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
      end else if (bus.pt_ready) begin
        pt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.ct_ready = ct_ready;
  assign bus.pt_valid = pt_valid_q;
  assign bus.pt_data  = pt_data_q;
  assign bus.pt_last  = pt_last_q;
  assign bus.beat_cnt = beat_cnt_q;
`ifdef TRIVIUM_KS_MON_EN
  assign bus.ks_mon   = ks_mon_q;
`endif

endmodule

// File: tb/tb_trivium_decrypt.sv
// Scoreboard bench for trivium_decrypt: a bit-serial Trivium model (standard
// 1-based register numbering) produces keystream; the driver pushes expected
// plaintext on each accepted ciphertext beat and a monitor pops on pt drain.
module tb_trivium_decrypt;
  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  trivium_decrypt_if #(.W(W)) bus ();

  trivium_decrypt #(.W(W), .WARMUP(1152)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] pt;
    logic         last;
    logic [W-1:0] ct;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] msg_ct[$];
  logic [W-1:0] msg_pt[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           ms[1:288];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference Trivium, bit-serial, registers s1..s288.
  task automatic model_round(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
    ms[1] = t3;
    for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = t2;
  endtask

  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    bit z;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ms[i+1]  = k[i];
      ms[i+94] = v[i];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    for (int i = 0; i < 1152; i++) model_round(z);
  endtask

  task automatic model_word(output logic [W-1:0] w);
    bit z;
    for (int b = W - 1; b >= 0; b--) begin
      model_round(z);
      w[b] = z;
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  // Monitor: pop expected beat on every pt handshake; check hold stability.
  initial begin
    bit           hv;
    logic [W-1:0] hd;
    logic         hl;
    exp_t         e;
    hv = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hv = 0;
      end else begin
        if (hv && bus.pt_valid) begin
          check("pt_data_stable", bus.pt_data, hd);
          check("pt_last_stable", bus.pt_last, hl);
        end
        if (bus.pt_valid && bus.pt_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pt: got %0h, expected no beat", bus.pt_data);
          end else begin
            e = exp_q.pop_front();
            check("pt_data", bus.pt_data, e.pt);
            check("pt_last", bus.pt_last, e.last);
`ifdef TRIVIUM_KS_MON_EN
            check("ks_mon_xor", bus.ks_mon ^ bus.pt_data, e.ct);
`endif
          end
          hv = 0;
        end else if (bus.pt_valid) begin
          hv = 1;
          hd = bus.pt_data;
          hl = bus.pt_last;
        end else begin
          hv = 0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [79:0] k, input logic [79:0] v);
    int t = 0;
    @(posedge clk); #1;
    bus.ct_valid = 1'b0;
    bus.pt_ready = 1'b1;
    @(negedge clk);
    while (!bus.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_start", bus.ready, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.key   = k;
    bus.iv    = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_load(k, v);
  endtask

  task automatic build_random(input int n);
    logic [W-1:0] w, p;
    msg_ct.delete();
    msg_pt.delete();
    for (int i = 0; i < n; i++) begin
      model_word(w);
      p = rand_word();
      msg_pt.push_back(p);
      msg_ct.push_back(p ^ w);
    end
  endtask

  task automatic run_msg(input int pr_pct, input int cv_pct, input int hold_at,
                         input int abort_after);
    int   idx = 0;
    int   cyc = 0;
    int   hold_left = 0;
    int   hold_acc = 0;
    bit   held = 0;
    bit   in_hold;
    int   n = msg_ct.size();
    exp_t e;
    while (idx < n && cyc < 20000) begin
      @(posedge clk); #1;
      in_hold = 0;
      if (!held && idx == hold_at) begin
        held      = 1;
        hold_left = 10;
      end
      bus.ct_data = msg_ct[idx];
      bus.ct_last = (idx == n - 1);
      if (hold_left > 0) begin
        in_hold      = 1;
        hold_left--;
        bus.ct_valid = 1'b1;
        bus.pt_ready = 1'b0;
      end else begin
        bus.ct_valid = ($urandom_range(99) < cv_pct);
        bus.pt_ready = ($urandom_range(99) < pr_pct);
      end
      @(negedge clk);
      if (in_hold && hold_left == 0) check("ct_ready_backpressure", bus.ct_ready, 1'b0);
      if (bus.ct_valid && bus.ct_ready) begin
        if (in_hold) hold_acc++;
        e.pt   = msg_pt[idx];
        e.last = (idx == n - 1);
        e.ct   = msg_ct[idx];
        exp_q.push_back(e);
        idx++;
      end
      cyc++;
      if (abort_after > 0 && idx == abort_after) break;
    end
    if (held) check("hold_accepts_le1", (hold_acc <= 1), 1'b1);
    if (cyc >= 20000) check("msg_timeout_beats", idx, n);
  endtask

  task automatic drain(input bit pend_start);
    int t = 0;
    @(posedge clk); #1;
    bus.ct_valid = 1'b0;
    bus.ct_last  = 1'b0;
    if (pend_start) begin
      bus.pt_ready = 1'b0;
      bus.start    = 1'b1;
      bus.key      = rand80();
      @(negedge clk);
      check("ready_while_pt_pending", bus.ready, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("start_ignored_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
    end
    bus.pt_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.pt_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("drain_timeout_left", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] hello[5];
    logic [79:0]  rk, rv;
    logic [W-1:0] ct0, pt0;
    exp_t         e;

    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.iv       = '0;
    bus.ct_valid = 1'b0;
    bus.ct_data  = '0;
    bus.ct_last  = 1'b0;
    bus.pt_ready = 1'b1;

    // Reset values
    #12;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ct_ready", bus.ct_ready, 1'b0);
    check("rst_pt_valid", bus.pt_valid, 1'b0);
    check("rst_pt_data", bus.pt_data, '0);
    check("rst_beat_cnt", bus.beat_cnt, '0);
    @(negedge clk);
    reset = 1'b1;

    // Warm-up timing with a 1-beat message waiting at the input
    do_start(80'h0, 80'h0);
    bus.ct_valid = 1'b1;
    bus.ct_data  = '0;
    bus.ct_last  = 1'b1;
    @(negedge clk);
    check("warm_busy", bus.busy, 1'b1);
    check("warm_ready", bus.ready, 1'b0);
    for (int k = 0; k < 144; k++) begin
      check("ct_ready_warm", bus.ct_ready, 1'b0);
      @(negedge clk);
    end
    check("ct_ready_run", bus.ct_ready, 1'b1);
    model_word(w);
    e.pt = w; e.last = 1'b1; e.ct = '0;
    exp_q.push_back(e);
    drain(1'b0);
    check("one_beat_cnt", bus.beat_cnt, 16'd1);
    check("one_beat_idle", bus.ready, 1'b1);

    // Keystream extraction: zero ciphertext, key=0, iv=0
    do_start(80'h0, 80'h0);
    msg_ct.delete();
    msg_pt.delete();
    for (int i = 0; i < 64; i++) begin
      model_word(w);
      msg_ct.push_back('0);
      msg_pt.push_back(w);
    end
    run_msg(70, 80, -1, 0);
    drain(1'b0);
    check("ks_beat_cnt", bus.beat_cnt, 16'd64);

    // Round trip "Hello"; start attempted while the last beat is pending
    do_start(80'h0123456789ABCDEF0123, 80'h0);
    msg_ct.delete();
    msg_pt.delete();
    for (int i = 0; i < 5; i++) begin
      model_word(w);
      msg_pt.push_back(hello[i]);
      msg_ct.push_back(hello[i] ^ w);
    end
    run_msg(100, 100, -1, 0);
    drain(1'b1);
    check("hello_beat_cnt", bus.beat_cnt, 16'd5);
    check("hello_idle", bus.ready, 1'b1);

    // Backpressure: pt_ready held low for 10 cycles mid-message
    do_start(rand80(), rand80());
    build_random(20);
    run_msg(90, 90, 7, 0);
    drain(1'b0);
    check("bp_beat_cnt", bus.beat_cnt, 16'd20);

    // Random messages with random handshake density
    for (int m = 0; m < 3; m++) begin
      do_start(rand80(), rand80());
      build_random(1 + $urandom_range(29));
      run_msg(30 + $urandom_range(70), 30 + $urandom_range(70), -1, 0);
      drain(1'b0);
      check("rand_beat_cnt", bus.beat_cnt, msg_ct.size());
    end

    // Asynchronous reset mid-RUN after 3 beats, then restart with same key/iv
    rk = rand80();
    rv = rand80();
    do_start(rk, rv);
    build_random(8);
    ct0 = msg_ct[0];
    pt0 = msg_pt[0];
    run_msg(100, 100, -1, 3);
    @(posedge clk); #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("arst_ready", bus.ready, 1'b1);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_ct_ready", bus.ct_ready, 1'b0);
    check("arst_pt_valid", bus.pt_valid, 1'b0);
    check("arst_pt_data", bus.pt_data, '0);
    check("arst_pt_last", bus.pt_last, 1'b0);
    check("arst_beat_cnt", bus.beat_cnt, '0);
    bus.ct_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_start(rk, rv);
    msg_ct.delete();
    msg_pt.delete();
    msg_ct.push_back(ct0);
    msg_pt.push_back(pt0);
    run_msg(100, 100, -1, 0);
    drain(1'b0);
    check("arst_restart_cnt", bus.beat_cnt, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trivium_decrypt.md
Name: trivium_decrypt

Overview:
- Streaming Trivium decryptor. It is the receive-side counterpart of the team's Trivium keystream encryptor.
- Loads an 80-bit key and an 80-bit IV, then runs the 1152-round warm-up.
- Generates W keystream bits per clock and XORs them with incoming ciphertext beats to produce plaintext.
- Sits between the link receive buffer and the payload consumer. Ciphertext in and plaintext out each use a valid/ready handshake.

Parameters:
- W, 8, bits per beat and keystream bits per clock. Must be a power of two, 1..64, so that W divides 1152.
- WARMUP, 1152, warm-up rounds before keystream output (4*288).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; accepted only when ready=1.
- key  input  80  key; sampled on the accepted start.
- iv  input  80  IV; sampled on the accepted start.
- ready  output  1  idle and able to accept start.
- busy  output  1  warm-up or run in progress.
- ct_valid  input  1  ciphertext beat valid.
- ct_ready  output  1  ciphertext beat accepted when ct_valid & ct_ready.
- ct_data  input  W  ciphertext beat.
- ct_last  input  1  final beat of the message.
- pt_valid  output  1  plaintext beat valid.
- pt_ready  input  1  consumer accepts the plaintext beat.
- pt_data  output  W  plaintext beat.
- pt_last  output  1  final plaintext beat.
- beat_cnt  output  16  beats accepted since the last start (saturates at 65535).

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - ready=1; busy=0; ct_ready=0; pt_valid=0; pt_data=0; pt_last=0; beat_cnt=0.
  - Internal 288-bit state and warm-up counter are cleared.
  - Reset mid-operation aborts the message. Any pending pt beat is dropped.
- State layout and round:
  - On start the state loads to {3'b111, 112'b0, iv, 13'b0, key}; key occupies bits 79:0.
  - One round:
    - t1=s65^s92, t2=s161^s176, t3=s242^s287; keystream bit z=t1^t2^t3.
    - t1'=t1^(s90&s91)^s170; t2'=t2^(s174&s175)^s263; t3'=t3^(s285&s286)^s68.
    - s[92:0]<={s[91:0],t3'}; s[176:93]<={s[175:93],t1'}; s[287:177]<={s[286:177],t2'}.
  - Each advancing cycle applies W rounds combinationally unrolled.
  - Keystream word: bit W-1 is z of round 0 of that cycle; bit 0 is z of round W-1 (MSB-first).
- FSM states:
  - IDLE: ready=1.
    - start & ready at edge T: load state, clear beat_cnt, go to WARM.
    - start while not ready is ignored.
    - ready = (FSM==IDLE) & !pt_valid.
  - WARM: busy=1. Advances W rounds per cycle for WARMUP/W cycles (144 at W=8), then goes to RUN. ct_ready=0 throughout.
  - RUN: busy=1.
    - ct_ready = !pt_valid | pt_ready (single output register with pass-through on drain).
    - On ct handshake: pt_data <= ct_data ^ ks_word; pt_last <= ct_last; pt_valid <= 1; state advances W rounds; beat_cnt++.
    - The state does not advance without a handshake.
    - On handshake with ct_last=1: go to IDLE.
- Output handshake:
  - pt_valid clears on pt_ready unless a new beat is captured in the same cycle.
  - pt_data and pt_last are held stable while pt_valid & !pt_ready.
- Latency: ciphertext handshake at edge N gives pt_valid=1 after edge N (1 cycle).
- Back-to-back throughput: 1 beat per cycle while pt_ready=1.
- Boundary conditions:
  - ct_valid in IDLE or WARM is not accepted.
  - A 1-beat message (ct_last on the first beat) is legal.
  - A simultaneous pt drain and ct accept keeps pt_valid=1 with the new data.
  - start is not accepted until the final pt beat drains.

Optional Feature:
- Macro: TRIVIUM_KS_MON_EN.
- Defined: adds output port ks_mon[W-1:0], registered alongside pt_data, holding the keystream word used for the current pt_data; reset value 0.
- Undefined: port absent; no extra registers. Decrypt behaviour is identical in both builds.

Test Plan:
- Warm-up timing, W=8, key=0, iv=0: start at edge T -> busy=1, ready=0; ct_ready=0 until RUN is entered 144 cycles after T; ct_ready=1 the cycle after.
- Keystream extraction: 64 beats of ct_data=8'h00 with key=80'h0, iv=80'h0 -> pt_data equals the bit-serial golden model's z sequence from round 1152 on, MSB-first per beat; beat_cnt=64.
- Round trip: encrypt 0x48656C6C6F ("Hello") with the team's encryptor under key=80'h0123456789ABCDEF0123, iv=80'h0 -> decrypted pt = 48 65 6C 6C 6F; pt_last on the 5th beat; FSM back in IDLE.
- Backpressure: hold pt_ready=0 for 10 cycles mid-message -> ct_ready=0 after one accepted beat; pt_data stable; no keystream advance; full data intact after release.
- Async reset mid-RUN (after 3 beats) -> all outputs at reset values immediately; new start with the same key/iv reproduces identical first-beat plaintext.
- (KS_MON build) ks_mon ^ pt_data == the captured ct_data on every beat of the test-2 stream.
